down2x_box: RTL and testbench

// - 2:1 box-filter downscaler, the inverse direction of the Hq2x upscaler: consumes a

---
 rtl/video_scale_pkg.sv | 23 ++
 rtl/down2x_ram.sv | 23 ++
 rtl/down2x_box.sv | 133 +++++++++++++
 tb/tb_down2x_box.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/video_scale_pkg.sv
// rtl/video_scale_pkg.sv - shared pixel format helpers for the 2x scaler paths
package video_scale_pkg;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    function automatic int dwidth(input int half_depth);
        return (half_depth != 0) ? 11 : 23;
    endfunction

    function automatic int cwidth(input int half_depth);
        return (half_depth != 0) ? 4 : 8;
    endfunction

    // LSB position of channel c (0=R, 1=G, 2=B) in a packed pixel
    function automatic int chan_lsb(input int c, input int cw);
        return c * cw;
    endfunction

endpackage

// File: rtl/down2x_ram.sv
// rtl/down2x_ram.sv - simple dual-port RAM, one write port, one registered read port
module down2x_ram #(
    parameter int AW    = 9,
    parameter int DW    = 24,
    parameter int DEPTH = 512
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_q <= r_mem[i_raddr];
    end

endmodule

// File: rtl/down2x_box.sv
// rtl/down2x_box.sv - 2:1 box-filter downscaler, one rounded-mean pixel per 2x2 input block
module down2x_box
    import video_scale_pkg::*;
#(
    parameter int LENGTH     = 512,
    parameter int HALF_DEPTH = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ce_in,
    input  logic [dwidth(HALF_DEPTH):0] inputpixel,
    input  logic                      reset_line,
    input  logic                      reset_frame,
    input  logic                      ce_out,
    input  logic                      hblank,
    output logic [dwidth(HALF_DEPTH):0] outpixel,
    output logic                      line_ready
);

    localparam int DWIDTH = dwidth(HALF_DEPTH);
    localparam int CW     = cwidth(HALF_DEPTH);
    localparam int AW     = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int SW     = 3 * (CW + 1);
    localparam logic [AW:0]   X_MAX  = (AW+1)'(2 * LENGTH - 1);
    localparam logic [AW-1:0] RX_MAX = AW'(LENGTH - 1);

    logic              r_old_rl, r_old_rf, r_frame_pend, r_line_act;
    logic [AW:0]       r_x;
    logic              r_x_full, r_y, r_wbuf, r_rbuf;
    logic [DWIDTH:0]   r_pair;
    logic [AW-1:0]     r_read_x;

    logic              w_start, w_rf_rise, w_rf_fall, w_proc, w_end_odd, w_y;
    logic [AW:0]       w_x;
    logic [SW-1:0]     w_hsum, w_sum_q;
    logic [DWIDTH:0]   w_avg, w_out_q;

    assign w_start   = ce_in & r_old_rl & ~reset_line;
    assign w_rf_rise = ce_in & ~r_old_rf & reset_frame;
    assign w_rf_fall = ce_in & r_old_rf & ~reset_frame;
    // A frame boundary seen since the last line start makes the new line even
    assign w_y       = w_start ? (~r_y & ~(r_frame_pend | w_rf_fall)) : r_y;
    assign w_x       = w_start ? '0 : r_x;
    assign w_proc    = ce_in & ~reset_line & (w_start | (r_line_act & ~r_x_full));
    assign w_end_odd = r_line_act & r_y & (w_start | w_rf_rise);

    for (genvar c = 0; c < 3; c++) begin : g_ch
        localparam int LSB = chan_lsb(c, CW);
        logic [CW-1:0] w_pe, w_po;
        logic [CW:0]   w_q;
        logic [CW+1:0] w_tot, w_rnd;

        assign w_pe  = r_pair[LSB +: CW];
        assign w_po  = inputpixel[LSB +: CW];
        assign w_q   = w_sum_q[c*(CW+1) +: CW+1];
        assign w_tot = {1'b0, w_q} + {2'b00, w_pe} + {2'b00, w_po};
        assign w_rnd = w_tot + (CW+2)'(2);
        assign w_hsum[c*(CW+1) +: CW+1] = {1'b0, w_pe} + {1'b0, w_po};
        assign w_avg[LSB +: CW]          = w_rnd[CW+1:2];
    end

    down2x_ram #(.AW(AW), .DW(SW), .DEPTH(LENGTH)) u_sum_ram (
        .clk     (clk),
        .i_we    (w_proc & w_x[0] & ~w_y),
        .i_waddr (w_x[AW:1]),
        .i_wdata (w_hsum),
        .i_re    (w_proc & ~w_x[0] & w_y),
        .i_raddr (w_x[AW:1]),
        .o_q     (w_sum_q)
    );

    // Write and read always target opposite halves, selected by the LSB
    down2x_ram #(.AW(AW+1), .DW(DWIDTH+1), .DEPTH(2*LENGTH)) u_out_ram (
        .clk     (clk),
        .i_we    (w_proc & w_x[0] & w_y),
        .i_waddr ({w_x[AW:1], r_wbuf}),
        .i_wdata (w_avg),
        .i_re    (1'b1),
        .i_raddr ({r_read_x, r_rbuf}),
        .o_q     (w_out_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_old_rl     <= 1'b0;
            r_old_rf     <= 1'b0;
            r_frame_pend <= 1'b0;
            r_line_act   <= 1'b0;
            r_x          <= '0;
            r_x_full     <= 1'b0;
            r_y          <= 1'b0;
            r_wbuf       <= 1'b0;
            r_rbuf       <= 1'b0;
            r_pair       <= '0;
            r_read_x     <= '0;
            outpixel     <= '0;
            line_ready   <= 1'b0;
        end else begin
            line_ready <= 1'b0;
            if (ce_in) begin
                r_old_rl <= reset_line;
                r_old_rf <= reset_frame;
            end
            if (w_rf_fall) r_frame_pend <= 1'b1;
            if (w_rf_rise) r_line_act <= 1'b0;
            if (w_start) begin
                r_y          <= w_y;
                r_line_act   <= 1'b1;
                r_frame_pend <= 1'b0;
            end
            if (w_end_odd) begin
                r_wbuf     <= ~r_wbuf;
                r_rbuf     <= r_wbuf;
                line_ready <= 1'b1;
            end
            if (w_proc) begin
                if (!w_x[0]) r_pair <= inputpixel;
                if (w_x == X_MAX) begin
                    r_x_full <= 1'b1;
                end else begin
                    r_x      <= w_x + (AW+1)'(1);
                    r_x_full <= 1'b0;
                end
            end
            if (ce_out) begin
                outpixel <= w_out_q;
                if (hblank)                r_read_x <= '0;
                else if (r_read_x != RX_MAX) r_read_x <= r_read_x + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_down2x_box.sv
// tb/tb_down2x_box.sv - directed self-checking bench for down2x_box
module tb_down2x_box;

    localparam int LEN = 8;

    logic        clk = 1'b0;
    logic        reset_n, ce_in, reset_line, reset_frame, ce_out, hblank;
    logic [23:0] inputpixel;
    logic [23:0] outpixel_f;
    logic [11:0] outpixel_h;
    logic        line_ready_f, line_ready_h;

    always #5 clk = ~clk;

    down2x_box #(.LENGTH(LEN), .HALF_DEPTH(0)) u_full (
        .clk(clk), .reset_n(reset_n), .ce_in(ce_in), .inputpixel(inputpixel),
        .reset_line(reset_line), .reset_frame(reset_frame), .ce_out(ce_out),
        .hblank(hblank), .outpixel(outpixel_f), .line_ready(line_ready_f)
    );

    down2x_box #(.LENGTH(LEN), .HALF_DEPTH(1)) u_half (
        .clk(clk), .reset_n(reset_n), .ce_in(ce_in), .inputpixel(inputpixel[11:0]),
        .reset_line(reset_line), .reset_frame(reset_frame), .ce_out(ce_out),
        .hblank(hblank), .outpixel(outpixel_h), .line_ready(line_ready_h)
    );

    typedef struct packed {
        logic [23:0] p0, p1, p2, p3, exp;
    } vec_t;

    vec_t        tbl [0:7];
    logic [23:0] even_px [0:31];
    logic [23:0] odd_px  [0:31];
    logic [23:0] exp_px  [0:15];
    logic [23:0] got_f   [0:15];
    logic [11:0] got_h   [0:15];
    int          errors = 0, checks = 0;
    int          lr_f = 0, lr_h = 0, lr0;

    always @(posedge clk) begin
        if (line_ready_f === 1'b1) lr_f++;
        if (line_ready_h === 1'b1) lr_h++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] avg4(input logic [23:0] a, b, c, d);
        logic [23:0] r;
        int s;
        for (int ch = 0; ch < 3; ch++) begin
            s = int'(a[ch*8 +: 8]) + int'(b[ch*8 +: 8]) + int'(c[ch*8 +: 8]) + int'(d[ch*8 +: 8]) + 2;
            r[ch*8 +: 8] = 8'(s / 4);
        end
        return r;
    endfunction

    task automatic tick_ce(input logic rl, input logic [23:0] px);
        @(negedge clk);
        ce_in = 1'b1; reset_line = rl; inputpixel = px;
        @(negedge clk);
        ce_in = 1'b0;
    endtask

    task automatic send_line(input int n, input bit odd);
        tick_ce(1'b1, 24'h0);
        tick_ce(1'b1, 24'h0);
        for (int i = 0; i < n; i++) tick_ce(1'b0, odd ? odd_px[i] : even_px[i]);
        tick_ce(1'b1, 24'h0);
    endtask

    task automatic frame_sync();
        reset_frame = 1'b1;
        tick_ce(1'b1, 24'h0);
        tick_ce(1'b1, 24'h0);
        reset_frame = 1'b0;
        tick_ce(1'b1, 24'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic read_out(input int n);
        @(negedge clk); ce_out = 1'b1; hblank = 1'b1;
        @(negedge clk); ce_out = 1'b0; hblank = 1'b0;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            ce_out = 1'b1;
            @(negedge clk);
            ce_out = 1'b0;
            got_f[i] = outpixel_f;
            got_h[i] = outpixel_h;
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{24'h404040, 24'h404040, 24'h404040, 24'h404040, 24'h404040};
        tbl[1] = '{24'h404040, 24'h404040, 24'h404040, 24'h404040, 24'h404040};
        tbl[2] = '{24'h000001, 24'h000002, 24'h000002, 24'h000002, 24'h000002};
        tbl[3] = '{24'h000001, 24'h000001, 24'h000001, 24'h000002, 24'h000001};
        tbl[4] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        tbl[5] = '{24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h000000, 24'h404040};
        tbl[6] = '{24'h0A0003, 24'h140003, 24'h1E0003, 24'h290103, 24'h190003};
        tbl[7] = '{24'h008002, 24'h008002, 24'h008001, 24'h007F01, 24'h008002};

        reset_n = 1'b0; ce_in = 1'b0; reset_line = 1'b1; reset_frame = 1'b0;
        ce_out = 1'b0; hblank = 1'b0; inputpixel = '0;
        repeat (3) @(negedge clk);
        check("reset_outpixel_full", {8'h0, outpixel_f}, 32'h0);
        check("reset_outpixel_half", {20'h0, outpixel_h}, 32'h0);
        check("reset_line_ready", {31'h0, line_ready_f}, 32'h0);
        reset_n = 1'b1;

        // Table of 2x2 blocks laid out across one even/odd line pair
        for (int b = 0; b < 8; b++) begin
            even_px[2*b] = tbl[b].p0; even_px[2*b+1] = tbl[b].p1;
            odd_px[2*b]  = tbl[b].p2; odd_px[2*b+1]  = tbl[b].p3;
        end
        frame_sync();
        lr0 = lr_f;
        send_line(16, 1'b0);
        send_line(16, 1'b1);
        frame_sync();
        check("table_line_ready", lr_f - lr0, 1);
        read_out(10);
        for (int b = 0; b < 8; b++) check($sformatf("table_blk%0d", b), {8'h0, got_f[b]}, {8'h0, tbl[b].exp});
        check("table_rx_sat8", {8'h0, got_f[8]}, {8'h0, tbl[7].exp});
        check("table_rx_sat9", {8'h0, got_f[9]}, {8'h0, tbl[7].exp});

        // Saturation: 2*LEN+6 pixels, the surplus ones must be ignored
        for (int i = 0; i < 22; i++) begin
            even_px[i] = (i < 16) ? {8'(i*9+3), 8'(i*17), 8'(250-i*11)} : 24'hFFFFFF;
            odd_px[i]  = (i < 16) ? {8'(i*13), 8'(200-i*7), 8'(i*i)} : 24'hFFFFFF;
        end
        for (int j = 0; j < 8; j++) exp_px[j] = avg4(even_px[2*j], even_px[2*j+1], odd_px[2*j], odd_px[2*j+1]);
        lr0 = lr_f;
        send_line(22, 1'b0);
        send_line(22, 1'b1);
        frame_sync();
        check("sat_line_ready", lr_f - lr0, 1);
        read_out(10);
        for (int j = 0; j < 10; j++) check($sformatf("sat_px%0d", j), {8'h0, got_f[j]}, {8'h0, exp_px[(j < 8) ? j : 7]});

        // Frame sync after an even line must make the next line even again
        for (int i = 0; i < 4; i++) even_px[i] = 24'h123456;
        lr0 = lr_f;
        send_line(4, 1'b0);
        frame_sync();
        check("fsync_even_no_line", lr_f - lr0, 0);
        even_px[0] = 24'h102030; even_px[1] = 24'h102030; even_px[2] = 24'h000000; even_px[3] = 24'h000000;
        odd_px[0]  = 24'h102030; odd_px[1]  = 24'h102030; odd_px[2]  = 24'h000000; odd_px[3]  = 24'h000003;
        send_line(4, 1'b0);
        send_line(4, 1'b1);
        check("fsync_no_early_line", lr_f - lr0, 0);
        frame_sync();
        check("fsync_line_ready", lr_f - lr0, 1);
        read_out(2);
        check("fsync_px0", {8'h0, got_f[0]}, 32'h102030);
        check("fsync_px1", {8'h0, got_f[1]}, 32'h000001);

        // Reset in the middle of an odd line
        for (int i = 0; i < 4; i++) even_px[i] = 24'h808080;
        lr0 = lr_f;
        send_line(4, 1'b0);
        tick_ce(1'b1, 24'h0);
        for (int i = 0; i < 3; i++) tick_ce(1'b0, 24'hAAAAAA);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_outpixel", {8'h0, outpixel_f}, 32'h0);
        check("midreset_line_ready", {31'h0, line_ready_f}, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tick_ce(1'b0, 24'h555555);
        tick_ce(1'b0, 24'h555555);
        frame_sync();
        check("midreset_no_line", lr_f - lr0, 0);
        even_px[0] = 24'h0F0F0F; even_px[1] = 24'h111111; even_px[2] = 24'h202020; even_px[3] = 24'h000000;
        odd_px[0]  = 24'h0F0F0F; odd_px[1]  = 24'h0F0F0F; odd_px[2]  = 24'h202020; odd_px[3]  = 24'h000004;
        send_line(4, 1'b0);
        send_line(4, 1'b1);
        frame_sync();
        check("postreset_line_ready", lr_f - lr0, 1);
        read_out(2);
        check("postreset_px0", {8'h0, got_f[0]}, 32'h101010);
        check("postreset_px1", {8'h0, got_f[1]}, 32'h101011);

        // 12-bit packed RGB444 instance
        even_px[0] = 24'hFFF; even_px[1] = 24'h000; even_px[2] = 24'h888; even_px[3] = 24'h888;
        even_px[4] = 24'hFFF; even_px[5] = 24'hFFF;
        odd_px[0]  = 24'h000; odd_px[1]  = 24'h000; odd_px[2]  = 24'h888; odd_px[3]  = 24'h887;
        odd_px[4]  = 24'hFFF; odd_px[5]  = 24'hFFF;
        lr0 = lr_h;
        send_line(6, 1'b0);
        send_line(6, 1'b1);
        frame_sync();
        check("half_line_ready", lr_h - lr0, 1);
        read_out(3);
        check("half_px0", {20'h0, got_h[0]}, 32'h444);
        check("half_px1", {20'h0, got_h[1]}, 32'h888);
        check("half_px2", {20'h0, got_h[2]}, 32'hFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
